atanh_sar_4bit: RTL and testbench

- Sequential inverse of the 4-bit tanh activation units. Takes a tanh-domain code y (unsigned Q0.4) and returns the largest x code (unsigned Q2.2) whose exact quantised tanh does not exceed y.
- Search is successive approximation, MSB first, one bit per cycle. Each step uses a combinational forward tanh ROM.
- Sits beside the activation library as the decode/inverse end. Used for characterisation and for inverse mapping of quantised activations.

---
 rtl/atanh_pkg.sv | 21 ++
 rtl/tanh_q22_rom.sv | 11 +
 rtl/atanh_sar_4bit.sv | 93 +++++++++
 tb/tb_atanh_sar_4bit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/atanh_pkg.sv
// Shared types and constants for the 4-bit atanh successive-approximation inverse.
// The forward table is quantised tanh: round(16*tanh(k/4)) saturated at 15.
package atanh_pkg;

  localparam int unsigned XW = 4;
  localparam int unsigned YW = 4;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  localparam logic [YW-1:0] TANH_Q22_Q04 [16] = '{
    4'd0,  4'd4,  4'd7,  4'd10, 4'd12, 4'd14, 4'd14, 4'd15,
    4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15
  };

  localparam logic [YW-1:0] Y_SAT = 4'd15;

endpackage

// File: rtl/tanh_q22_rom.sv
// Combinational forward tanh: Q2.2 x code in, Q0.4 tanh code out.
module tanh_q22_rom
  import atanh_pkg::*;
(
  input  logic [XW-1:0] x_i,
  output logic [YW-1:0] t_o
);

  assign t_o = TANH_Q22_Q04[x_i];

endmodule

// File: rtl/atanh_sar_4bit.sv
// Sequential inverse of 4-bit tanh: largest Q2.2 x whose quantised tanh <= y, one bit per cycle.
// Optional out_sat_o port is enabled by defining ATANH_SAT_FLAG_EN.
module atanh_sar_4bit
  import atanh_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [YW-1:0] in_y_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
`ifdef ATANH_SAT_FLAG_EN
  output logic          out_sat_o,
`endif
  output logic [XW-1:0] out_x_o
);

  state_e        state_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] res_q;
  logic [1:0]    step_q;
  logic          out_valid_q;
  logic [XW-1:0] cand;
  logic [YW-1:0] t_cand;
`ifdef ATANH_SAT_FLAG_EN
  logic          out_sat_q;
`endif

  assign cand = res_q | (XW'(1) << step_q);

  tanh_q22_rom u_rom (
    .x_i (cand),
    .t_o (t_cand)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      y_q         <= '0;
      res_q       <= '0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef ATANH_SAT_FLAG_EN
      out_sat_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            y_q     <= in_y_i;
            res_q   <= '0;
            step_q  <= 2'd3;
            state_q <= StSearch;
          end
        end
        StSearch: begin
          // Table is monotonic, so keeping the bit whenever T[cand] <= y yields the largest k.
          if (t_cand <= y_q) begin
            res_q <= cand;
          end
          if (step_q == 2'd0) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
`ifdef ATANH_SAT_FLAG_EN
            out_sat_q   <= (y_q == Y_SAT);
`endif
          end else begin
            step_q <= step_q - 2'd1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
`ifdef ATANH_SAT_FLAG_EN
            out_sat_q   <= 1'b0;
`endif
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = out_valid_q;
  assign out_x_o     = res_q;
`ifdef ATANH_SAT_FLAG_EN
  assign out_sat_o   = out_sat_q;
`endif

endmodule

// File: tb/tb_atanh_sar_4bit.sv
// Self-checking bench for atanh_sar_4bit: directed plan steps plus randomized operands
// against a table-scan reference model.
module tb_atanh_sar_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_y;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_x;
`ifdef ATANH_SAT_FLAG_EN
  logic       out_sat;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit noise    = 1'b0;

  int tanh_tab [16] = '{0, 4, 7, 10, 12, 14, 14, 15, 15, 15, 15, 15, 15, 15, 15, 15};
  int sweep_exp [16] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 4, 4, 6, 15};

  atanh_sar_4bit dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_y_i      (in_y),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef ATANH_SAT_FLAG_EN
    .out_sat_o   (out_sat),
`endif
    .out_x_o     (out_x)
  );

  always #5 clk = ~clk;

  function automatic int ref_atanh(input int y);
    int best = 0;
    for (int k = 0; k < 16; k++) begin
      if (tanh_tab[k] <= y) best = k;
    end
    return best;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles of backpressure once the result is valid.
  task automatic do_op(input int y, input int exp_x, input int hold);
    check("ready_before_accept", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_y     = 4'(y);
    tick();
    in_valid = 1'b0;
    in_y     = 4'($urandom);
    for (int i = 1; i <= 4; i++) begin
      check("busy_in_search", 32'(in_ready), 0);
      check("no_early_valid", 32'(out_valid), 0);
      if (noise) begin
        in_valid = 1'($urandom);
        in_y     = 4'($urandom);
      end
      tick();
    end
    check("valid_after_4", 32'(out_valid), 1);
    check("out_x", 32'(out_x), 32'(exp_x));
    check("busy_in_done", 32'(in_ready), 0);
`ifdef ATANH_SAT_FLAG_EN
    check("out_sat", 32'(out_sat), 32'(y == 15));
`endif
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_y     = 4'($urandom);
      end
      tick();
      check("hold_valid", 32'(out_valid), 1);
      check("hold_x", 32'(out_x), 32'(exp_x));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_drop", 32'(out_valid), 0);
    check("ready_back", 32'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_y      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_x", 32'(out_x), 0);
    check("rst_ready", 32'(in_ready), 1);
`ifdef ATANH_SAT_FLAG_EN
    check("rst_sat", 32'(out_sat), 0);
`endif

    do_op(10, 3, 0);

    for (int y = 0; y < 16; y++) begin
      do_op(y, sweep_exp[y], 0);
    end

    do_op(13, 4, 7);

    // Reset during the second search cycle abandons the operand.
    in_valid = 1'b1;
    in_y     = 4'd12;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_x", 32'(out_x), 0);
    check("midrst_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("midrst_no_result", 32'(out_valid), 0);
    end
    do_op(7, 2, 0);

    do_op(15, 15, 0);
    do_op(14, 6, 0);

    // Stray in_valid pulses while busy must be ignored.
    noise = 1'b1;
    do_op(7, 2, 2);
    noise = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_second_result", 32'(out_valid), 0);
    end

    noise = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int y;
      y = int'($urandom_range(15, 0));
      do_op(y, ref_atanh(y), int'($urandom_range(3, 0)));
    end
    noise = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
